// File: rtl/demux_1_4_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// The select decode lives here so every user agrees on channel numbering.
package demux_pkg;

    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // One-hot write-enable pattern for a channel number.
    function automatic logic [N_OUT-1:0] sel_decode(input sel_t sel);
        logic [N_OUT-1:0] onehot;
        onehot = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/demux_1_4_stream_out_slot.sv
// One downstream channel: single-entry valid/data register plus a saturating
// delivered-word counter. Its FULL/EMPTY state is simply valid_q.
module out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic             slot_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             deliver;

    assign deliver    = valid_q && out_ready;
    assign slot_ready = !valid_q || out_ready;

    // A write in the same cycle as a drain keeps the slot full with the new word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end else if (deliver) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (deliver && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demultiplexer: steers each accepted word by sel
// into one of four independent single-entry output slots.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  sel_t             sel,
    output logic [N_OUT-1:0] out_valid,
    input  logic [N_OUT-1:0] out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    logic [N_OUT-1:0] slot_ready;
    logic [N_OUT-1:0] wr_en;
    logic [WIDTH-1:0] data_w [N_OUT];
    logic [CNT_W-1:0] cnt_w  [N_OUT];

    // Upstream readiness looks only at the selected slot, so a stalled
    // channel holds back only words addressed to it.
    assign in_ready = slot_ready[sel];
    assign wr_en    = (in_valid && in_ready) ? sel_decode(sel) : '0;

    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        out_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (wr_en[i]),
            .wr_data    (in_data),
            .out_ready  (out_ready[i]),
            .cnt_clr    (cnt_clr),
            .slot_ready (slot_ready[i]),
            .out_valid  (out_valid[i]),
            .out_data   (data_w[i]),
            .cnt        (cnt_w[i])
        );
    end

    assign out_data0 = data_w[0];
    assign out_data1 = data_w[1];
    assign out_data2 = data_w[2];
    assign out_data3 = data_w[3];

    assign cnt0 = cnt_w[0];
    assign cnt1 = cnt_w[1];
    assign cnt2 = cnt_w[2];
    assign cnt3 = cnt_w[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed self-checking bench for demux_1_4_stream: routing, backpressure,
// streaming throughput, counter saturation/clear and asynchronous reset.
module tb_demux_1_4_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] sel;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [3:0] out_data0, out_data1, out_data2, out_data3;
    logic       cnt_clr;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;

    int checks;
    int failures;

    demux_1_4_stream #(
        .WIDTH (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One rising edge, then park on the falling edge where outputs are stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        sel       = 2'd0;
        out_ready = 4'b0000;
        cnt_clr   = 1'b0;

        // Reset before any clock edge takes effect immediately.
        #2 rst = 1'b0;
        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'h0);
        check_output("rst_cnt0", 32'(cnt0), 32'd0);
        check_output("rst_cnt3", 32'(cnt3), 32'd0);
        check_output("rst_data2", 32'(out_data2), 32'h0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single routing to channel 2, then a blocked second word.
        sel = 2'd2; in_data = 4'hA; in_valid = 1'b1;
        #1 check_output("route_ready_empty", 32'(in_ready), 32'd1);
        tick();
        check_output("route_valid_0100", 32'(out_valid), 32'b0100);
        check_output("route_data2_A", 32'(out_data2), 32'hA);
        in_data = 4'h7;
        #1 check_output("route_ready_full", 32'(in_ready), 32'd0);
        tick();
        check_output("route_held_valid", 32'(out_valid), 32'b0100);
        check_output("route_held_data2", 32'(out_data2), 32'hA);
        sel = 2'd1; in_data = 4'h5;
        #1 check_output("route_ready_ch1", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_output("route_valid_0110", 32'(out_valid), 32'b0110);
        check_output("route_data1_5", 32'(out_data1), 32'h5);
        check_output("route_data2_still_A", 32'(out_data2), 32'hA);
        out_ready = 4'b0110;
        tick();
        out_ready = 4'b0000;
        check_output("drain_valid", 32'(out_valid), 32'b0000);
        check_output("drain_cnt1", 32'(cnt1), 32'd1);
        check_output("drain_cnt2", 32'(cnt2), 32'd1);

        // Back-to-back streaming on channel 3.
        sel = 2'd3; out_ready = 4'b1000; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 4'(k);
            #1 check_output("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            check_output("stream_data3", 32'(out_data3), 32'(k));
            check_output("stream_valid3", 32'(out_valid[3]), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check_output("stream_cnt3", 32'(cnt3), 32'd4);
        check_output("stream_drained", 32'(out_valid), 32'b0000);
        out_ready = 4'b0000;

        // Backpressure: channel 0 holds 4'hC while stalled; idle inputs ignored.
        sel = 2'd0; in_data = 4'hC; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_output("stall_valid0", 32'(out_valid[0]), 32'd1);
            check_output("stall_data0", 32'(out_data0), 32'hC);
        end
        check_output("stall_in_ready", 32'(in_ready), 32'd0);
        check_output("stall_cnt0", 32'(cnt0), 32'd0);
        out_ready = 4'b0001;
        #1 check_output("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        out_ready = 4'b0000;
        check_output("release_cnt0", 32'(cnt0), 32'd1);
        check_output("release_valid0", 32'(out_valid[0]), 32'd0);

        // Saturation: 300 words on channel 1 on top of the earlier delivery.
        sel = 2'd1; out_ready = 4'b0010; in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            in_data = 4'(k);
            tick();
        end
        check_output("sat_cnt1", 32'(cnt1), 32'd255);
        check_output("sat_valid1", 32'(out_valid[1]), 32'd1);

        // Clear while channel 1 is handshaking and saturated.
        in_valid = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_output("clr_cnt1_sat", 32'(cnt1), 32'd0);
        check_output("clr_cnt0", 32'(cnt0), 32'd0);
        check_output("clr_cnt3", 32'(cnt3), 32'd0);

        // Clear must win over a non-saturated increment.
        in_valid = 1'b1; in_data = 4'h6;
        tick();
        tick();
        check_output("preclr_cnt1", 32'(cnt1), 32'd1);
        in_valid = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_output("clr_wins_cnt1", 32'(cnt1), 32'd0);
        check_output("clr_valid1", 32'(out_valid[1]), 32'd0);
        out_ready = 4'b0000;

        // Reset mid-operation between edges discards held words.
        sel = 2'd0; in_data = 4'h3; in_valid = 1'b1;
        tick();
        sel = 2'd2; in_data = 4'h9;
        tick();
        in_valid = 1'b0;
        check_output("pre_rst_valid", 32'(out_valid), 32'b0101);
        #2 rst = 1'b0;
        #1;
        check_output("mid_rst_valid", 32'(out_valid), 32'b0000);
        check_output("mid_rst_data0", 32'(out_data0), 32'h0);
        check_output("mid_rst_data2", 32'(out_data2), 32'h0);
        check_output("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b1;
        out_ready = 4'b1111;
        tick();
        check_output("post_rst_valid", 32'(out_valid), 32'b0000);
        check_output("post_rst_cnt0", 32'(cnt0), 32'd0);
        check_output("post_rst_cnt2", 32'(cnt2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
